mem_port_arbiter: RTL and testbench

//  Shares one single-ported data/instruction memory between the multi-cycle MIPS core and a DMA/loader requester.

---
 rtl/mem_port_arbiter_pkg.sv | 7 +
 rtl/mem_port_arbiter_if.sv | 14 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 10 +
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and owner codes for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's handshake and data bus into the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on a tie the side that did not go last wins
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_last_owner,
  output logic [1:0] o_gnt
);
  always_comb o_gnt = &i_req ? (i_last_owner == OWN_CPU ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU and DMA with round-robin, fixed-latency accesses
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave dma,
  output logic [ADDR_W-1:0] o_mem_adrs,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [1:0]        o_owner
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  state_t            r_state, w_state_nx;
  logic [1:0]        r_owner, r_last_owner, w_gnt;
  logic [LW-1:0]     r_lat_cnt;
  logic              r_we, r_mem_read, r_mem_write, r_cpu_ack, r_dma_ack;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata, r_cpu_rdata, r_dma_rdata;
  logic              w_grant, w_done, w_we;
  rr_arbiter2 u_rr (
    .i_req       ({dma.req, cpu.req}),
    .i_last_owner(r_last_owner),
    .o_gnt       (w_gnt)
  );
  always_comb begin
    w_grant    = r_state == ST_IDLE && |w_gnt;
    w_done     = r_state == ST_ACCESS && r_lat_cnt == '0;
    w_we       = w_gnt[0] ? cpu.we : dma.we;
    w_addr     = w_gnt[0] ? cpu.addr : dma.addr;
    w_wdata    = w_gnt[0] ? cpu.wdata : dma.wdata;
    w_state_nx = w_grant ? ST_ACCESS : w_done ? ST_RESP : r_state == ST_RESP ? ST_IDLE : r_state;
  end
  always_ff @(posedge clk)
    r_state <= rst ? ST_IDLE : w_state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_NONE;
      r_last_owner <= OWN_DMA;
      r_lat_cnt    <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
    end else begin
      r_cpu_ack <= w_done && r_owner == OWN_CPU;
      r_dma_ack <= w_done && r_owner == OWN_DMA;
      if (w_grant) begin
        r_owner     <= w_gnt[0] ? OWN_CPU : OWN_DMA;
        r_we        <= w_we;
        r_addr      <= w_addr;
        r_wdata     <= w_wdata;
        r_lat_cnt   <= LAT_INIT;
        r_mem_read  <= ~w_we;
        r_mem_write <= w_we;
      end
      if (r_state == ST_ACCESS && r_lat_cnt != '0)
        r_lat_cnt <= r_lat_cnt - 1'b1;
      if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (!r_we && r_owner == OWN_CPU) r_cpu_rdata <= i_mem_rdata;
        if (!r_we && r_owner == OWN_DMA) r_dma_rdata <= i_mem_rdata;
      end
      if (r_state == ST_RESP) begin
        r_last_owner <= r_owner;
        r_owner      <= OWN_NONE;
      end
    end
  end
  assign cpu.rdata   = r_cpu_rdata;
  assign cpu.ack     = r_cpu_ack;
  assign dma.rdata   = r_dma_rdata;
  assign dma.ack     = r_dma_ack;
  assign o_mem_adrs  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario checks of the shared memory port arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_adrs, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  owner;
  int          errors = 0;
  int          checks = 0;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if.slave),
    .dma        (dma_if.slave),
    .o_mem_adrs (mem_adrs),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_mem_read (mem_read),
    .o_mem_write(mem_write),
    .o_owner    (owner)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
    dma_if.req = 0; dma_if.we = 0; dma_if.addr = 0; dma_if.wdata = 0;
    mem_rdata = 0;
    rst = 1;
    step(); step();
    checks++; if ({mem_read, mem_write, cpu_if.ack, dma_if.ack} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, cpu_if.ack, dma_if.ack}); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", owner); end
    checks++; if (cpu_if.rdata !== 32'h0 || dma_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_if.rdata, dma_if.rdata); end
    checks++; if (mem_adrs !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_adrs, mem_wdata); end
    rst = 0;
  endtask
  task automatic test_cpu_read();
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 32'h40; mem_rdata = 32'hDEADBEEF;
    step();
    checks++; if ({mem_read, mem_write} !== 2'b10 || mem_adrs !== 32'h40) begin errors++; $display("FAIL rd_c1: got rd=%b wr=%b adr=%h want 1 0 40", mem_read, mem_write, mem_adrs); end
    checks++; if (owner !== 2'b01 || cpu_if.ack !== 1'b0) begin errors++; $display("FAIL rd_c1_owner: got owner=%b ack=%b want 01 0", owner, cpu_if.ack); end
    step();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rd_c2: got rd=%b want 1", mem_read); end
    step();
    checks++; if (cpu_if.ack !== 1'b1 || dma_if.ack !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rd_c3_ack: got cack=%b dack=%b rd=%b want 1 0 0", cpu_if.ack, dma_if.ack, mem_read); end
    checks++; if (cpu_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3_data: got %h want deadbeef", cpu_if.rdata); end
    cpu_if.req = 0;
    step();
    checks++; if (cpu_if.ack !== 1'b0 || owner !== 2'b00 || cpu_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c4: got ack=%b owner=%b data=%h want 0 00 deadbeef", cpu_if.ack, owner, cpu_if.rdata); end
  endtask
  task automatic test_dma_write();
    dma_if.req = 1; dma_if.we = 1; dma_if.addr = 32'h100; dma_if.wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    step();
    checks++; if ({mem_read, mem_write} !== 2'b01 || mem_wdata !== 32'h12345678 || mem_adrs !== 32'h100) begin errors++; $display("FAIL wr_c1: got rd=%b wr=%b wd=%h adr=%h want 0 1 12345678 100", mem_read, mem_write, mem_wdata, mem_adrs); end
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL wr_c1_owner: got %b want 10", owner); end
    step();
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_c2: got wr=%b wd=%h want 1 12345678", mem_write, mem_wdata); end
    step();
    checks++; if (dma_if.ack !== 1'b1 || cpu_if.ack !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL wr_c3_ack: got dack=%b cack=%b wr=%b want 1 0 0", dma_if.ack, cpu_if.ack, mem_write); end
    checks++; if (dma_if.rdata !== 32'h0 || cpu_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_c3_rdata: got d=%h c=%h want 0 deadbeef", dma_if.rdata, cpu_if.rdata); end
    dma_if.req = 0; dma_if.we = 0;
    step();
  endtask
  task automatic test_both_after_reset();
    rst = 1;
    step();
    rst = 0;
    cpu_if.req = 1; cpu_if.addr = 32'h200; dma_if.req = 1; dma_if.addr = 32'h300; mem_rdata = 32'hA5A50001;
    step();
    checks++; if (owner !== 2'b01 || mem_adrs !== 32'h200) begin errors++; $display("FAIL tie_c1: got owner=%b adr=%h want 01 200", owner, mem_adrs); end
    step(); step();
    checks++; if (cpu_if.ack !== 1'b1 || dma_if.ack !== 1'b0) begin errors++; $display("FAIL tie_c3: got cack=%b dack=%b want 1 0", cpu_if.ack, dma_if.ack); end
    cpu_if.req = 0;
    step();
    checks++; if (owner !== 2'b00 || mem_read !== 1'b0) begin errors++; $display("FAIL tie_c4: got owner=%b rd=%b want 00 0", owner, mem_read); end
    step();
    checks++; if (owner !== 2'b10 || mem_read !== 1'b1 || mem_adrs !== 32'h300) begin errors++; $display("FAIL tie_c5: got owner=%b rd=%b adr=%h want 10 1 300", owner, mem_read, mem_adrs); end
    step();
    checks++; if (mem_read !== 1'b1 || dma_if.ack !== 1'b0) begin errors++; $display("FAIL tie_c6: got rd=%b dack=%b want 1 0", mem_read, dma_if.ack); end
    step();
    checks++; if (dma_if.ack !== 1'b1 || cpu_if.ack !== 1'b0 || dma_if.rdata !== 32'hA5A50001) begin errors++; $display("FAIL tie_c7: got dack=%b cack=%b data=%h want 1 0 a5a50001", dma_if.ack, cpu_if.ack, dma_if.rdata); end
    dma_if.req = 0;
    step();
  endtask
  task automatic test_back_to_back();
    logic [1:0] order [6];
    int n = 0;
    int bad = 0;
    for (int i = 0; i < 6; i++) order[i] = 2'b00;
    for (int c = 0; c < 80 && n < 6; c++) begin
      cpu_if.req = 1; dma_if.req = 1;
      step();
      if ((cpu_if.ack && dma_if.ack) || (mem_read && mem_write)) bad++;
      if (cpu_if.ack && n < 6) begin order[n] = 2'b01; n++; cpu_if.req = 0; end
      if (dma_if.ack && n < 6) begin order[n] = 2'b10; n++; dma_if.req = 0; end
    end
    cpu_if.req = 0; dma_if.req = 0;
    step();
    checks++; if (n !== 6) begin errors++; $display("FAIL b2b_count: got %0d acks want 6", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d overlaps want 0", bad); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (order[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_order[%0d]: got %b want %b", i, order[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
  endtask
  task automatic test_addr_hold();
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 32'h40;
    step();
    cpu_if.addr = 32'h80;
    checks++; if (mem_adrs !== 32'h40) begin errors++; $display("FAIL hold_c1: got %h want 40", mem_adrs); end
    step();
    checks++; if (mem_adrs !== 32'h40 || mem_read !== 1'b1) begin errors++; $display("FAIL hold_c2: got adr=%h rd=%b want 40 1", mem_adrs, mem_read); end
    step();
    checks++; if (cpu_if.ack !== 1'b1) begin errors++; $display("FAIL hold_c3: got ack=%b want 1", cpu_if.ack); end
    cpu_if.req = 0;
    step();
  endtask
  task automatic test_reset_mid_access();
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 32'h44; mem_rdata = 32'h11112222;
    step();
    checks++; if (mem_read !== 1'b1 || owner !== 2'b01) begin errors++; $display("FAIL rst_c1: got rd=%b owner=%b want 1 01", mem_read, owner); end
    rst = 1;
    step();
    rst = 0; cpu_if.req = 0;
    checks++; if (mem_read !== 1'b0 || owner !== 2'b00 || cpu_if.ack !== 1'b0 || cpu_if.rdata !== 32'h0) begin errors++; $display("FAIL rst_c2: got rd=%b owner=%b ack=%b data=%h want 0 00 0 0", mem_read, owner, cpu_if.ack, cpu_if.rdata); end
    step();
    checks++; if (cpu_if.ack !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rst_c3: got ack=%b rd=%b want 0 0", cpu_if.ack, mem_read); end
    cpu_if.req = 1; dma_if.req = 1;
    step();
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rst_tie: got owner=%b want 01", owner); end
    step(); step();
    cpu_if.req = 0;
    step(); step(); step(); step();
    checks++; if (dma_if.ack !== 1'b1) begin errors++; $display("FAIL rst_dma_after: got dack=%b want 1", dma_if.ack); end
    dma_if.req = 0;
    step();
  endtask
  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_both_after_reset();
    test_back_to_back();
    test_addr_hold();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
